// File: rtl/truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sequencer
// Brief    : Sweeps every input vector of a small combinational function in
//            ascending order, holds each for a programmable settle time,
//            samples the function output into a truth-table word and compares
//            the sweep against an expected table.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sequencer #(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [(1<<N_INPUTS)-1:0]   expected,
    input  logic                       fut_out,
    output logic [N_INPUTS-1:0]        fut_in,
    output logic                       busy,
    output logic                       done,
    output logic [(1<<N_INPUTS)-1:0]   table_out,
    output logic                       mismatch,
    output logic [N_INPUTS:0]          err_count,
    output logic [N_INPUTS-1:0]        first_err
);

    localparam int c_TBL_W = 1 << N_INPUTS;
    localparam int c_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [N_INPUTS-1:0] c_VEC_LAST = '1;
    localparam logic [N_INPUTS-1:0] c_VEC_ONE  = N_INPUTS'(1);
    localparam logic [N_INPUTS:0]   c_ERR_ONE  = (N_INPUTS + 1)'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_APPLY  = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [N_INPUTS-1:0] r_vec;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_TBL_W-1:0]  r_expected;
    logic [c_TBL_W-1:0]  r_table;
    logic                r_mismatch;
    logic [N_INPUTS:0]   r_err_count;
    logic [N_INPUTS-1:0] r_first_err;
    logic                w_busy;

    // State register; reset overrides any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: settle countdown in APPLY, terminal vector check in SAMPLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (start) w_next_state = c_ST_APPLY;
            c_ST_APPLY:  if (r_cnt == c_CNT_LAST) w_next_state = c_ST_SAMPLE;
            c_ST_SAMPLE: w_next_state = (r_vec == c_VEC_LAST) ? c_ST_DONE : c_ST_APPLY;
            c_ST_DONE:   w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    // Vector/settle counters and result capture; results persist until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec       <= '0;
            r_cnt       <= '0;
            r_expected  <= '0;
            r_table     <= '0;
            r_mismatch  <= 1'b0;
            r_err_count <= '0;
            r_first_err <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_expected  <= expected;
                        r_vec       <= '0;
                        r_cnt       <= '0;
                        r_table     <= '0;
                        r_mismatch  <= 1'b0;
                        r_err_count <= '0;
                        r_first_err <= '0;
                    end
                end
                c_ST_APPLY: begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
                c_ST_SAMPLE: begin
                    r_table[r_vec] <= fut_out;
                    if (fut_out != r_expected[r_vec]) begin
                        r_err_count <= r_err_count + c_ERR_ONE;
                        // Only the lowest failing vector is recorded; vectors ascend.
                        if (!r_mismatch) begin
                            r_first_err <= r_vec;
                            r_mismatch  <= 1'b1;
                        end
                    end
                    // Terminal compare precedes the increment, so vec never wraps.
                    if (r_vec != c_VEC_LAST) begin
                        r_vec <= r_vec + c_VEC_ONE;
                        r_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_busy    = (r_state == c_ST_APPLY) || (r_state == c_ST_SAMPLE);
    assign busy      = w_busy;
    assign done      = (r_state == c_ST_DONE);
    assign fut_in    = w_busy ? r_vec : '0;
    assign table_out = r_table;
    assign mismatch  = r_mismatch;
    assign err_count = r_err_count;
    assign first_err = r_first_err;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_truth_table_sequencer
// Brief    : Directed self-checking bench for truth_table_sequencer, covering
//            an N=2/S=1 instance and an N=3/S=3 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_sequencer;

    logic clk;
    logic rst;

    // Instance A: N=2, S=1
    logic       start_a;
    logic [3:0] exp_a;
    logic       fut_out_a;
    logic [1:0] fut_in_a;
    logic       busy_a;
    logic       done_a;
    logic [3:0] table_a;
    logic       mis_a;
    logic [2:0] errc_a;
    logic [1:0] ferr_a;
    int         mode_a;

    // Instance B: N=3, S=3
    logic       start_b;
    logic [7:0] exp_b;
    logic       fut_out_b;
    logic [2:0] fut_in_b;
    logic       busy_b;
    logic       done_b;
    logic [7:0] table_b;
    logic       mis_b;
    logic [3:0] errc_b;
    logic [2:0] ferr_b;

    int checks;
    int failures;

    // Function under test models: mode 0 constant 1, mode 1 a XOR b, otherwise AND.
    assign fut_out_a = (mode_a == 0) ? 1'b1 : (mode_a == 1) ? ^fut_in_a : &fut_in_a;
    assign fut_out_b = &fut_in_b;

    truth_table_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(1)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .expected  (exp_a),
        .fut_out   (fut_out_a),
        .fut_in    (fut_in_a),
        .busy      (busy_a),
        .done      (done_a),
        .table_out (table_a),
        .mismatch  (mis_a),
        .err_count (errc_a),
        .first_err (ferr_a)
    );

    truth_table_sequencer #(.N_INPUTS(3), .SETTLE_CYCLES(3)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .expected  (exp_b),
        .fut_out   (fut_out_b),
        .fut_in    (fut_in_b),
        .busy      (busy_b),
        .done      (done_b),
        .table_out (table_b),
        .mismatch  (mis_b),
        .err_count (errc_b),
        .first_err (ferr_b)
    );

    // 10-time-unit clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done_a or the budget expires; cyc is the cycle index after the accepting edge.
    task automatic wait_done_a(input int start_c, input int max_c, output int cyc);
        cyc = start_c;
        while (done_a !== 1'b1 && cyc < max_c) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1; exp_a = 4'hF; exp_b = 8'h80;
        tick(); tick();
        checks++;
        if ({fut_in_a, busy_a, done_a, table_a, mis_a, errc_a, ferr_a} !== 14'd0) begin
            failures++;
            $display("FAIL reset_a: got fut_in=%b busy=%b done=%b table=%b mis=%b errc=%0d ferr=%0d, want all 0",
                     fut_in_a, busy_a, done_a, table_a, mis_a, errc_a, ferr_a);
        end
        checks++;
        if ({fut_in_b, busy_b, done_b, table_b, mis_b, errc_b, ferr_b} !== 21'd0) begin
            failures++;
            $display("FAIL reset_b: got fut_in=%b busy=%b done=%b table=%h, want all 0",
                     fut_in_b, busy_b, done_b, table_b);
        end
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        tick(); tick();
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_dropped: busy_a=%b busy_b=%b, want 0 0", busy_a, busy_b);
        end
    endtask

    task automatic test_constant();
        mode_a = 0; exp_a = 4'b1111;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (fut_in_a !== 2'((c - 1) / 2) || busy_a !== 1'b1 || done_a !== 1'b0) begin
                failures++;
                $display("FAIL const_seq c=%0d: fut_in=%b busy=%b done=%b, want fut_in=%0d busy=1 done=0",
                         c, fut_in_a, busy_a, done_a, (c - 1) / 2);
            end
            tick();
        end
        checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || fut_in_a !== 2'b00) begin
            failures++;
            $display("FAIL const_done: done=%b busy=%b fut_in=%b at cycle 9, want 1 0 00", done_a, busy_a, fut_in_a);
        end
        checks++;
        if (table_a !== 4'b1111 || mis_a !== 1'b0 || errc_a !== 3'd0 || ferr_a !== 2'd0) begin
            failures++;
            $display("FAIL const_result: table=%b mis=%b errc=%0d ferr=%0d, want 1111 0 0 0", table_a, mis_a, errc_a, ferr_a);
        end
        tick();
        checks++;
        if (done_a !== 1'b0 || table_a !== 4'b1111) begin
            failures++;
            $display("FAIL const_pulse_hold: done=%b table=%b, want 0 1111", done_a, table_a);
        end
    endtask

    task automatic test_mismatch();
        int cyc;
        mode_a = 1; exp_a = 4'b1000;
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done_a(1, 20, cyc);
        checks++;
        if (done_a !== 1'b1 || cyc != 9) begin
            failures++;
            $display("FAIL mism_latency: done=%b at cycle %0d, want done=1 at cycle 9", done_a, cyc);
        end
        checks++;
        if (table_a !== 4'b0110 || mis_a !== 1'b1 || errc_a !== 3'd3 || ferr_a !== 2'd1) begin
            failures++;
            $display("FAIL mism_result: table=%b mis=%b errc=%0d ferr=%0d, want 0110 1 3 1", table_a, mis_a, errc_a, ferr_a);
        end
        tick();
    endtask

    task automatic test_settle();
        exp_b = 8'h80;
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            checks++;
            if (fut_in_b !== 3'((c - 1) / 4) || busy_b !== 1'b1 || done_b !== 1'b0) begin
                failures++;
                $display("FAIL settle_seq c=%0d: fut_in=%0d busy=%b done=%b, want fut_in=%0d busy=1 done=0",
                         c, fut_in_b, busy_b, done_b, (c - 1) / 4);
            end
            tick();
        end
        checks++;
        if (done_b !== 1'b1 || table_b !== 8'h80 || mis_b !== 1'b0 || errc_b !== 4'd0) begin
            failures++;
            $display("FAIL settle_done: done=%b table=%h mis=%b errc=%0d at cycle 33, want 1 80 0 0",
                     done_b, table_b, mis_b, errc_b);
        end
        tick();
    endtask

    task automatic test_abort();
        int cyc;
        int stray;
        mode_a = 0; exp_a = 4'b1111;
        // start re-pulsed mid-sweep must not restart
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(); tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || fut_in_a !== 2'd1) begin
            failures++;
            $display("FAIL ignore_midsweep: busy=%b fut_in=%b at cycle 4, want 1 01", busy_a, fut_in_a);
        end
        wait_done_a(4, 20, cyc);
        checks++;
        if (done_a !== 1'b1 || cyc != 9) begin
            failures++;
            $display("FAIL ignore_latency: done=%b at cycle %0d, want done=1 at cycle 9", done_a, cyc);
        end
        tick(); tick();
        // reset mid-sweep discards partial results
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick(); tick(); tick(); tick();
        checks++;
        if (table_a !== 4'b0011 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL abort_partial: table=%b busy=%b at cycle 5, want 0011 1", table_a, busy_a);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || table_a !== 4'b0000 || fut_in_a !== 2'b00) begin
            failures++;
            $display("FAIL abort_reset: busy=%b done=%b table=%b fut_in=%b, want 0 0 0000 00", busy_a, done_a, table_a, fut_in_a);
        end
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_a === 1'b1 || busy_a === 1'b1) stray++;
            tick();
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL abort_no_done: %0d cycles with done/busy after reset, want 0", stray);
        end
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done_a(1, 20, cyc);
        checks++;
        if (done_a !== 1'b1 || cyc != 9 || table_a !== 4'b1111) begin
            failures++;
            $display("FAIL abort_recover: done=%b cycle=%0d table=%b, want 1 9 1111", done_a, cyc, table_a);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        mode_a = 1; exp_a = 4'b1000;
        start_a = 1'b1; tick();
        for (int c = 1; c <= 29; c++) begin
            checks++;
            if (done_a !== ((c == 9) || (c == 19) || (c == 29))) begin
                failures++;
                $display("FAIL b2b_done c=%0d: done=%b, want %0d", c, done_a, (c == 9) || (c == 19) || (c == 29));
            end
            if (c == 9 || c == 19 || c == 29) begin
                checks++;
                if (table_a !== 4'b0110 || errc_a !== 3'd3 || ferr_a !== 2'd1 || mis_a !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_result c=%0d: table=%b errc=%0d ferr=%0d mis=%b, want 0110 3 1 1",
                             c, table_a, errc_a, ferr_a, mis_a);
                end
            end
            tick();
        end
        start_a = 1'b0;
        tick();
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop: busy=%b after start released, want 0", busy_a);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        exp_a = '0; exp_b = '0; mode_a = 0;
        checks = 0; failures = 0;
        test_reset();
        test_constant();
        test_mismatch();
        test_settle();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Sequencer that drives an exhaustive truth-table sweep through a small combinational function under test (FUT). On each `start` it applies every input vector in ascending binary order, waits a programmable settle time, samples the FUT output, and packs the results into a truth-table word. It also compares the sweep against an expected table and reports mismatches, which gives the lab exercises a hardware self-check.

## Interface
- `N_INPUTS`, default 2: FUT input count; sweep length is 2^N_INPUTS vectors; legal range 1..6.
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling; must be ≥1.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `start` in, 1: request a sweep; acted on only in IDLE.
- `expected` in, 2^N_INPUTS: expected truth table, bit i = f(vector i); captured when `start` is accepted.
- `fut_out` in, 1: FUT output.
- `fut_in` out, N_INPUTS: vector currently driven to the FUT; MSB = first input (a).
- `busy` out, 1: high from the cycle after `start` is accepted through the last SAMPLE.
- `done` out, 1: one-cycle pulse when a sweep completes.
- `table_out` out, 2^N_INPUTS: captured truth table, bit i = sampled `fut_out` for vector i.
- `mismatch` out, 1: at least one bit of `table_out` differs from the captured `expected`.
- `err_count` out, N_INPUTS+1: number of mismatching vectors.
- `first_err` out, N_INPUTS: index of the lowest mismatching vector; 0 if none.

## Operation
- States: IDLE, APPLY, SAMPLE, DONE.
- **IDLE:** `fut_in`=0, `busy`=0. On `start`=1: latch `expected`, set vec=0 and settle counter=0, clear `table_out`, `err_count`, `mismatch` and `first_err`, then go to APPLY.
- **APPLY:** `fut_in`=vec. The counter increments every cycle. When the counter reaches SETTLE_CYCLES−1, go to SAMPLE. APPLY therefore lasts exactly SETTLE_CYCLES cycles.
- **SAMPLE:** `fut_in`=vec still held.
  - Write `fut_out` into `table_out[vec]`.
  - If `fut_out` ≠ expected[vec]: increment `err_count`; if this is the first error of the sweep, load `first_err`=vec and set `mismatch`=1.
  - If vec = 2^N_INPUTS−1, go to DONE. Otherwise vec+1, counter=0, and go back to APPLY.
- **DONE:** `done`=1 for this single cycle, `busy`=0, `fut_in`=0. Go to IDLE unconditionally.
- Results (`table_out`, `mismatch`, `err_count`, `first_err`) hold until the next accepted `start` or `rst`.
- `start` in APPLY, SAMPLE or DONE is ignored. It is not queued.
- The vec counter is N_INPUTS+0 bits wide. There is no wrap: the terminal compare happens before the increment.
- `err_count` is one bit wider than the index, so it can reach 2^N_INPUTS without overflowing.

## Timing
- Reset values: state=IDLE, `fut_in`=0, `busy`=0, `done`=0, `table_out`=0, `mismatch`=0, `err_count`=0, `first_err`=0.
- `rst` asserted mid-sweep: on the next edge everything returns to reset values. No `done` pulse occurs and partial results are discarded.
- `rst` and `start` high in the same cycle: reset wins and `start` is dropped.
- `start` accepted at edge k:
  - APPLY for vector 0 occupies cycles k+1 .. k+SETTLE_CYCLES.
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - DONE occupies cycle k+1+2^N_INPUTS·(SETTLE_CYCLES+1).
- Defaults (N=2, S=1): `done` is high in cycle k+9.
- `table_out` and the error outputs are final and valid in the `done` cycle.
- `fut_out` is sampled at the end of SAMPLE. A combinational FUT therefore gets at least SETTLE_CYCLES+1 cycles of stable input.
- `start` held high continuously gives back-to-back sweeps: one IDLE cycle between the DONE cycle and the next APPLY.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs 0 and `fut_in`=0; `start` while `rst`=1 → no sweep begins.
- **Constant FUT, N=2, S=1:** `fut_out` tied to 1, `expected`=4'b1111, pulse `start` at edge k → `fut_in` sequence 00,00,01,01,10,10,11,11; `done` at k+9; `table_out`=4'b1111, `mismatch`=0, `err_count`=0.
- **Mismatch reporting:** FUT = a XOR b, `expected`=4'b1000 → `table_out`=4'b0110, `mismatch`=1, `err_count`=3, `first_err`=1.
- **Settle parameter:** N=3, S=3, FUT = AND of all inputs → each vector held 3 cycles plus SAMPLE; `done` at k+33; `table_out`=8'h80.
- **Abort and ignore:** `start` re-pulsed mid-sweep → no restart, `done` still at k+9. `rst` asserted at k+5 → `busy`=0 next cycle, no `done`, `table_out`=0. A new `start` afterwards completes normally.
- **Back-to-back:** `start` held high for 30 cycles with N=2, S=1 → `done` pulses at k+9, k+19, k+29; results identical each sweep.
